// File: rtl/arb_pkg.sv
// Shared encodings and AXI constants for the sram-to-AXI arbiter.
package arb_pkg;

   typedef enum logic {
      AR_IDLE = 1'b0,
      AR_SEND = 1'b1
   } ar_state_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_SEND = 2'd1,
      W_RESP = 2'd2
   } w_state_t;

   localparam int ARB_INST_ID = 0;
   localparam int ARB_DATA_ID = 1;

   localparam logic [7:0] LEN_SINGLE = 8'd0;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] LOCK_NONE  = 2'b00;
   localparam logic [3:0] CACHE_NONE = 4'b0000;
   localparam logic [2:0] PROT_NONE  = 3'b000;

endpackage

// File: rtl/axi_wr_channel.sv
// Single-beat AXI write sequencer: AW and W issued together, then wait for B.
module axi_wr_channel
   import arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_accept,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [2:0]        i_size,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [3:0]        i_wstrb,
   input  logic              i_awready,
   input  logic              i_wready,
   input  logic              i_bvalid,
   output logic              o_idle,
   output logic              o_pending,
   output logic              o_done,
   output logic [ADDR_W-1:0] o_awaddr,
   output logic [2:0]        o_awsize,
   output logic              o_awvalid,
   output logic [DATA_W-1:0] o_wdata,
   output logic [3:0]        o_wstrb,
   output logic              o_wvalid,
   output logic              o_bready
);

   w_state_t          r_state, w_next;
   logic              r_awvalid, r_wvalid;
   logic [ADDR_W-1:0] r_awaddr;
   logic [2:0]        r_awsize;
   logic [DATA_W-1:0] r_wdata;
   logic [3:0]        r_wstrb;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= W_IDLE;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_awaddr  <= '0;
         r_awsize  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
      end else begin
         r_state <= w_next;
         if (i_accept) begin
            r_awaddr  <= i_addr;
            r_awsize  <= i_size;
            r_wdata   <= i_wdata;
            r_wstrb   <= i_wstrb;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
         end else begin
            // AW and W retire independently; either may finish first
            if (r_awvalid && i_awready) r_awvalid <= 1'b0;
            if (r_wvalid && i_wready)   r_wvalid  <= 1'b0;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         W_IDLE: if (i_accept) w_next = W_SEND;
         W_SEND: if ((!r_awvalid || i_awready) && (!r_wvalid || i_wready)) w_next = W_RESP;
         W_RESP: if (i_bvalid) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   assign o_idle    = (r_state == W_IDLE);
   assign o_pending = (r_state != W_IDLE);
   assign o_bready  = (r_state == W_RESP);
   assign o_done    = o_bready & i_bvalid;
   assign o_awaddr  = r_awaddr;
   assign o_awsize  = r_awsize;
   assign o_awvalid = r_awvalid;
   assign o_wdata   = r_wdata;
   assign o_wstrb   = r_wstrb;
   assign o_wvalid  = r_wvalid;

endmodule

// File: rtl/sram_axi_arbiter.sv
// Bridges the inst (read-only) and data sram-like ports onto one AXI3 master.
module sram_axi_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int ID_W    = 4,
   parameter int INST_ID = ARB_INST_ID,
   parameter int DATA_ID = ARB_DATA_ID
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_inst_sram_req,
   input  logic [1:0]        i_inst_sram_size,
   input  logic [ADDR_W-1:0] i_inst_sram_addr,
   output logic              o_inst_sram_addr_ok,
   output logic              o_inst_sram_data_ok,
   output logic [DATA_W-1:0] o_inst_sram_rdata,
   input  logic              i_data_sram_req,
   input  logic              i_data_sram_wr,
   input  logic [1:0]        i_data_sram_size,
   input  logic [3:0]        i_data_sram_wstrb,
   input  logic [ADDR_W-1:0] i_data_sram_addr,
   input  logic [DATA_W-1:0] i_data_sram_wdata,
   output logic              o_data_sram_addr_ok,
   output logic              o_data_sram_data_ok,
   output logic [DATA_W-1:0] o_data_sram_rdata,
   output logic [ID_W-1:0]   o_arid,
   output logic [ADDR_W-1:0] o_araddr,
   output logic [7:0]        o_arlen,
   output logic [2:0]        o_arsize,
   output logic [1:0]        o_arburst,
   output logic [1:0]        o_arlock,
   output logic [3:0]        o_arcache,
   output logic [2:0]        o_arprot,
   output logic              o_arvalid,
   input  logic              i_arready,
   input  logic [ID_W-1:0]   i_rid,
   input  logic [DATA_W-1:0] i_rdata,
   input  logic [1:0]        i_rresp,
   input  logic              i_rlast,
   input  logic              i_rvalid,
   output logic              o_rready,
   output logic [ID_W-1:0]   o_awid,
   output logic [ADDR_W-1:0] o_awaddr,
   output logic [7:0]        o_awlen,
   output logic [2:0]        o_awsize,
   output logic [1:0]        o_awburst,
   output logic [1:0]        o_awlock,
   output logic [3:0]        o_awcache,
   output logic [2:0]        o_awprot,
   output logic              o_awvalid,
   input  logic              i_awready,
   output logic [ID_W-1:0]   o_wid,
   output logic [DATA_W-1:0] o_wdata,
   output logic [3:0]        o_wstrb,
   output logic              o_wlast,
   output logic              o_wvalid,
   input  logic              i_wready,
   input  logic [ID_W-1:0]   i_bid,
   input  logic [1:0]        i_bresp,
   input  logic              i_bvalid,
   output logic              o_bready
);

   ar_state_t         r_ar_state, w_ar_next;
   logic [ID_W-1:0]   r_arid;
   logic [ADDR_W-1:0] r_araddr;
   logic [2:0]        r_arsize;
   logic              r_inst_busy, r_data_busy;
   logic              w_data_rd_grant, w_inst_rd_grant, w_wr_accept, w_raw_hit;
   logic              w_inst_rdok, w_data_rdok;
   logic              w_wr_idle, w_wr_pending, w_wr_done;
   logic              w_unused_ok;

   assign w_wr_accept = w_wr_idle & i_data_sram_req & i_data_sram_wr & ~r_data_busy;

   // Stall fetches that would overtake a store to the same word, including one accepted this cycle
   assign w_raw_hit = (w_wr_pending & (o_awaddr[ADDR_W-1:2] == i_inst_sram_addr[ADDR_W-1:2]))
                    | (w_wr_accept & (i_data_sram_addr[ADDR_W-1:2] == i_inst_sram_addr[ADDR_W-1:2]));

   always_comb begin
      w_ar_next       = r_ar_state;
      w_data_rd_grant = 1'b0;
      w_inst_rd_grant = 1'b0;
      case (r_ar_state)
         AR_IDLE: begin
            if (i_data_sram_req && !i_data_sram_wr && !r_data_busy) begin
               w_data_rd_grant = 1'b1;
               w_ar_next       = AR_SEND;
            end else if (i_inst_sram_req && !r_inst_busy && !w_raw_hit) begin
               w_inst_rd_grant = 1'b1;
               w_ar_next       = AR_SEND;
            end
         end
         AR_SEND: if (i_arready) w_ar_next = AR_IDLE;
         default: w_ar_next = AR_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ar_state <= AR_IDLE;
         r_arid     <= '0;
         r_araddr   <= '0;
         r_arsize   <= '0;
      end else begin
         r_ar_state <= w_ar_next;
         if (w_data_rd_grant) begin
            r_arid   <= ID_W'(DATA_ID);
            r_araddr <= i_data_sram_addr;
            r_arsize <= {1'b0, i_data_sram_size};
         end else if (w_inst_rd_grant) begin
            r_arid   <= ID_W'(INST_ID);
            r_araddr <= i_inst_sram_addr;
            r_arsize <= {1'b0, i_inst_sram_size};
         end
      end
   end

   // Returns without a matching outstanding request are swallowed
   assign w_inst_rdok = i_rvalid & (i_rid == ID_W'(INST_ID)) & r_inst_busy;
   assign w_data_rdok = i_rvalid & (i_rid == ID_W'(DATA_ID)) & r_data_busy;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_inst_busy <= 1'b0;
         r_data_busy <= 1'b0;
      end else begin
         if (w_inst_rd_grant)  r_inst_busy <= 1'b1;
         else if (w_inst_rdok) r_inst_busy <= 1'b0;
         if (w_data_rd_grant || w_wr_accept)  r_data_busy <= 1'b1;
         else if (w_data_rdok || w_wr_done)   r_data_busy <= 1'b0;
      end
   end

   axi_wr_channel #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_accept  (w_wr_accept),
      .i_addr    (i_data_sram_addr),
      .i_size    ({1'b0, i_data_sram_size}),
      .i_wdata   (i_data_sram_wdata),
      .i_wstrb   (i_data_sram_wstrb),
      .i_awready (i_awready),
      .i_wready  (i_wready),
      .i_bvalid  (i_bvalid),
      .o_idle    (w_wr_idle),
      .o_pending (w_wr_pending),
      .o_done    (w_wr_done),
      .o_awaddr  (o_awaddr),
      .o_awsize  (o_awsize),
      .o_awvalid (o_awvalid),
      .o_wdata   (o_wdata),
      .o_wstrb   (o_wstrb),
      .o_wvalid  (o_wvalid),
      .o_bready  (o_bready)
   );

   assign o_inst_sram_addr_ok = w_inst_rd_grant;
   assign o_inst_sram_data_ok = w_inst_rdok;
   assign o_inst_sram_rdata   = i_rdata;
   assign o_data_sram_addr_ok = w_data_rd_grant | w_wr_accept;
   assign o_data_sram_data_ok = w_data_rdok | w_wr_done;
   assign o_data_sram_rdata   = i_rdata;

   assign o_arid    = r_arid;
   assign o_araddr  = r_araddr;
   assign o_arsize  = r_arsize;
   assign o_arvalid = (r_ar_state == AR_SEND);
   assign o_arlen   = LEN_SINGLE;
   assign o_arburst = BURST_INCR;
   assign o_arlock  = LOCK_NONE;
   assign o_arcache = CACHE_NONE;
   assign o_arprot  = PROT_NONE;
   assign o_rready  = 1'b1;

   assign o_awid    = ID_W'(DATA_ID);
   assign o_awlen   = LEN_SINGLE;
   assign o_awburst = BURST_INCR;
   assign o_awlock  = LOCK_NONE;
   assign o_awcache = CACHE_NONE;
   assign o_awprot  = PROT_NONE;
   assign o_wid     = ID_W'(DATA_ID);
   assign o_wlast   = 1'b1;

   assign w_unused_ok = ^{i_rresp, i_rlast, i_bid, i_bresp};

endmodule

// File: doc/sram_axi_arbiter.md
Name: sram_axi_arbiter

Overview:
- Shares one AXI3 master port between the instruction-fetch sram-like port (read only) and the data sram-like port (read/write) driven by the EXE stage.
- Sequences AR/R/AW/W/B handshakes and returns addr_ok/data_ok to each requester.
- Sits in mycpu_top between the pipeline and the SoC AXI interconnect.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- ID_W, 4, AXI id width.
- INST_ID, 0, arid for instruction reads.
- DATA_ID, 1, arid/awid/wid for data accesses.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_sram_req  in  1  fetch request
- inst_sram_size  in  2  0=byte,1=half,2=word
- inst_sram_addr  in  ADDR_W  physical address
- inst_sram_addr_ok  out  1  request accepted this cycle
- inst_sram_data_ok  out  1  read data valid
- inst_sram_rdata  out  DATA_W  read data
- data_sram_req  in  1  data request
- data_sram_wr  in  1  1=store
- data_sram_size  in  2  access size
- data_sram_wstrb  in  4  byte enables
- data_sram_addr  in  ADDR_W  physical address
- data_sram_wdata  in  DATA_W  store data
- data_sram_addr_ok  out  1  request accepted
- data_sram_data_ok  out  1  load data valid / store complete
- data_sram_rdata  out  DATA_W  load data
- arid/araddr/arsize/arvalid  out  ID_W/ADDR_W/3/1  read address
- arready  in  1
- arlen/arburst/arlock/arcache/arprot  out  8/2/2/4/3  constants 0/2'b01/0/0/0
- rid/rdata/rresp/rlast/rvalid  in  ID_W/DATA_W/2/1/1  read data
- rready  out  1
- awid/awaddr/awsize/awvalid  out  ID_W/ADDR_W/3/1  write address; awlen/awburst/awlock/awcache/awprot constants as AR
- awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  ID_W/DATA_W/4/1/1  write data; wlast=1
- wready  in  1
- bid/bresp/bvalid  in  ID_W/2/1
- bready  out  1

Behaviour:
- Reset: arvalid, awvalid, wvalid, bready, addr_ok and data_ok outputs are 0; rready=1. FSMs go to IDLE and busy flags clear. Transactions outstanding at reset are abandoned.
- AR FSM: AR_IDLE, AR_SEND.
  - In AR_IDLE, grant a read with fixed priority: data beats inst.
  - The grant asserts that requester's addr_ok combinationally in the same cycle.
  - The grant latches arid/araddr/arsize={1'b0,size} and moves to AR_SEND.
  - AR_SEND holds arvalid and all AR fields stable until arready, then returns to AR_IDLE.
  - Minimum accept-to-arvalid latency is 1 cycle; the next AR accept is possible the cycle after the arready handshake.
- Outstanding rules:
  - At most one outstanding read for inst.
  - At most one outstanding transaction, read or write, for data.
  - A requester is not granted while its busy flag is set.
  - Busy sets on addr_ok and clears on the matching data_ok.
- RAW stall: an inst read is not granted while a data write is pending (accepted, bvalid not yet seen) with addr[31:2] equal to inst_sram_addr[31:2].
- R channel:
  - rready is constantly 1.
  - rvalid with rid==INST_ID gives inst_sram_data_ok=1 and inst_sram_rdata=rdata, combinational, the same cycle.
  - rvalid with rid==DATA_ID gives the same on the data port.
  - rvalid with any other rid, or with no matching busy flag, is consumed and ignored.
- Write path, sub-FSM states W_IDLE, W_SEND, W_RESP:
  - A data write is accepted in W_IDLE when data is not busy and no data read is granted that cycle.
  - Acceptance latches awaddr/awsize/wdata/wstrb, asserts awvalid and wvalid in the next cycle, and moves to W_SEND.
  - In W_SEND, each valid drops independently on its handshake; AW and W may complete in either order or together.
  - When both handshakes are done, move to W_RESP with bready=1.
  - bvalid in W_RESP gives data_sram_data_ok=1 and returns to W_IDLE.
- data_sram_data_ok is (rvalid & rid==DATA_ID) | (bvalid & bready). Both cannot be true together because of the one-outstanding rule.
- Simultaneous data read and inst read in AR_IDLE: data is granted and inst_sram_addr_ok=0. Inst is granted in the first idle cycle with no data read request.
- rresp and bresp are ignored (no bus-error exception).

Decomposition:
- Package arb_pkg holds AR/W state encodings, INST_ID/DATA_ID, and the AXI constants (BURST_INCR=2'b01, LEN_SINGLE=0).
- One sub-module: axi_wr_channel (W_IDLE/W_SEND/W_RESP FSM plus pending-address register exported for the RAW compare).

Test Plan:
- Inst read 0x1c000000 alone; arready on the 2nd AXI cycle; rvalid rid=0 rdata=0x02800c0c -> addr_ok at cycle 0, arvalid cycles 1-2, araddr=0x1c000000, inst_sram_data_ok for 1 cycle with rdata=0x02800c0c.
- Inst and data reads in the same cycle (data addr 0x00001004, size 2) -> data_sram_addr_ok=1, inst_sram_addr_ok=0, first arid=1; inst AR issued next with arid=0. Returns with rid=1 then rid=0, or reversed, route to the correct port.
- Store: wstrb=4'b0011, addr 0x8, wdata 0x0000beef; awready 2 cycles before wready -> awvalid drops after its handshake, wvalid holds until wready; bvalid -> data_sram_data_ok pulse. No second data addr_ok before then.
- RAW: data store to 0x100 pending, inst read 0x102 -> inst addr_ok held 0 until bvalid, granted the following cycle. An inst read to 0x104 is not stalled.
- Reset asserted while in W_SEND with awvalid=1 -> next cycle awvalid=wvalid=0, all ok outputs 0, new inst request accepted immediately.
- Stray rvalid rid=3 with nothing outstanding -> no data_ok on either port, FSMs unchanged.
